// File: rtl/line_mem_responder.sv
// Line-wide memory responder: one outstanding request, mem_ready pulses LATENCY cycles after accept, then a turnaround cycle.
// No backpressure on responses; requests are held by the requester until mem_ready. Optional MEM_ERR_CHK_EN adds sticky proto_err.
module line_mem_responder #(
   parameter int LATENCY    = 5,
   parameter int DEPTH_LOG2 = 10,
   parameter int LINE_W     = 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [27:0]       mem_addr,
   input  logic [LINE_W-1:0] mem_wdata,
   output logic [LINE_W-1:0] mem_rdata,
   output logic              mem_ready
`ifdef MEM_ERR_CHK_EN
   ,
   output logic              proto_err
`endif
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                  state_q;
   logic [7:0]              cnt_q;
   logic                    op_wr_q;
   logic [DEPTH_LOG2-1:0]   idx_q;
   logic [LINE_W-1:0]       wdata_q;
   logic [LINE_W-1:0]       rdata_q;
   logic                    mem_ready_q;
   logic [LINE_W-1:0]       mem_q [2**DEPTH_LOG2];

   logic access_fire;
   logic unused_addr_hi;

   assign access_fire    = (state_q == BUSY) && (cnt_q == 8'd0);
   // Upper line-address bits alias onto the stored depth.
   assign unused_addr_hi = ^mem_addr[27:DEPTH_LOG2];
   assign mem_ready      = mem_ready_q;
   assign mem_rdata      = rdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 8'd0;
         mem_ready_q <= 1'b0;
         rdata_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (mem_read || mem_write) begin
                  op_wr_q <= mem_write;
                  idx_q   <= mem_addr[DEPTH_LOG2-1:0];
                  wdata_q <= mem_wdata;
                  cnt_q   <= 8'(LATENCY - 1);
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               if (cnt_q == 8'd0) begin
                  mem_ready_q <= 1'b1;
                  rdata_q     <= op_wr_q ? '0 : mem_q[idx_q];
                  state_q     <= DONE;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            DONE: begin
               mem_ready_q <= 1'b0;
               rdata_q     <= '0;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Gated by !rst so a reset landing on the ready edge never commits the write.
   always_ff @(posedge clk) begin
      if (!rst && access_fire && op_wr_q) begin
         mem_q[idx_q] <= wdata_q;
      end
   end

`ifdef MEM_ERR_CHK_EN
   logic [27:0] addr_q;
   logic        err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         if (state_q == IDLE && (mem_read || mem_write)) begin
            addr_q <= mem_addr;
            if (mem_read && mem_write) err_q <= 1'b1;
         end
         if (state_q == BUSY &&
             ((op_wr_q ? !mem_write : !mem_read) || (mem_addr != addr_q))) begin
            err_q <= 1'b1;
         end
      end
   end

   assign proto_err = err_q;
`endif

endmodule
